// File: rtl/note_sequencer.sv
// note_sequencer
// Duration-aware player that feeds the music box tone generator. It walks a
// synchronous note ROM one entry at a time and holds each note for its
// encoded number of duration ticks. Optional silent gap ticks can follow each
// note. It supports pause, song select with restart, and end-of-song wrap.
//
// Ports
//   clk        in   1   system clock
//   RESET      in   1   asynchronous, active-high reset
//   sound_off  in   1   1 = pause: freeze position and output silence
//   song_sel   in   1   0 = song 1 (ROM 0..255), 1 = song 2 (ROM 256..511)
//   rom_addr   out  9   {song, idx}, built from registers only
//   rom_data   in   10  [9:6] duration in ticks (0 = end marker), [5:0] note (0 = rest);
//                       valid one cycle after rom_addr
//   fullnote   out  10  {4'b0, note} while sounding, otherwise 0
//   step_idx   out  8   index of the current entry within the song
//   song_done  out  1   one-cycle pulse when playback wraps to entry 0
module note_sequencer #(
    parameter int unsigned TICK_DIV  = 1_562_500,
    parameter int unsigned GAP_TICKS = 1
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       sound_off,
    input  logic       song_sel,
    output logic [8:0] rom_addr,
    input  logic [9:0] rom_data,
    output logic [9:0] fullnote,
    output logic [7:0] step_idx,
    output logic       song_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_GAP
    } state_t;

    state_t          r_state;
    logic            r_song;
    logic [7:0]      r_idx;
    logic [PW-1:0]   r_prescaler;
    logic [3:0]      r_durCtr;
    logic [5:0]      r_note;
    logic [GW-1:0]   r_gapCtr;
    logic            r_songDone;

    state_t          w_state;
    logic            w_song;
    logic [7:0]      w_idx;
    logic [PW-1:0]   w_prescaler;
    logic [3:0]      w_durCtr;
    logic [5:0]      w_note;
    logic [GW-1:0]   w_gapCtr;
    logic            w_songDone;
    logic            w_tick;
    logic [3:0]      w_romDur;
    logic [5:0]      w_romNote;

    assign w_romDur  = rom_data[9:6];
    assign w_romNote = rom_data[5:0];
    assign w_tick    = (r_prescaler == TICK_LAST);

    // State and datapath registers. Reset returns to IDLE with everything cleared.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_song      <= 1'b0;
            r_idx       <= 8'd0;
            r_prescaler <= '0;
            r_durCtr    <= 4'd0;
            r_note      <= 6'd0;
            r_gapCtr    <= '0;
            r_songDone  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_song      <= w_song;
            r_idx       <= w_idx;
            r_prescaler <= w_prescaler;
            r_durCtr    <= w_durCtr;
            r_note      <= w_note;
            r_gapCtr    <= w_gapCtr;
            r_songDone  <= w_songDone;
        end
    end

    // Next-state logic. A change of song takes priority over everything else,
    // then pause, then normal sequencing.
    always_comb begin
        w_state     = r_state;
        w_song      = r_song;
        w_idx       = r_idx;
        w_prescaler = r_prescaler;
        w_durCtr    = r_durCtr;
        w_note      = r_note;
        w_gapCtr    = r_gapCtr;
        w_songDone  = 1'b0;

        if (song_sel != r_song) begin
            w_song      = song_sel;
            w_idx       = 8'd0;
            w_prescaler = '0;
            w_state     = S_FETCH;
        end else if (sound_off) begin
            // Everything holds. A ROM read that is in flight is dropped, so
            // the read is reissued on resume.
            case (r_state)
                S_WAIT:                         w_state = S_FETCH;
                S_IDLE, S_FETCH, S_PLAY, S_GAP: w_state = r_state;
                default:                        w_state = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE:  w_state = S_FETCH;
                S_FETCH: w_state = S_WAIT;
                S_WAIT: begin
                    if (w_romDur == 4'd0) begin
                        w_idx      = 8'd0;
                        w_songDone = 1'b1;
                        w_state    = S_FETCH;
                    end else begin
                        w_durCtr    = w_romDur;
                        w_note      = w_romNote;
                        w_prescaler = '0;
                        w_state     = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (w_tick) begin
                        w_prescaler = '0;
                        w_durCtr    = r_durCtr - 4'd1;
                        if (r_durCtr == 4'd1) begin
                            if (GAP_TICKS != 0) begin
                                w_gapCtr = GAP_LOAD;
                                w_state  = S_GAP;
                            end else begin
                                w_idx      = r_idx + 8'd1;
                                w_songDone = (r_idx == 8'hFF);
                                w_state    = S_FETCH;
                            end
                        end
                    end else begin
                        w_prescaler = r_prescaler + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        w_prescaler = '0;
                        if (r_gapCtr == GW'(1)) begin
                            w_idx      = r_idx + 8'd1;
                            w_songDone = (r_idx == 8'hFF);
                            w_state    = S_FETCH;
                        end else begin
                            w_gapCtr = r_gapCtr - 1'b1;
                        end
                    end else begin
                        w_prescaler = r_prescaler + 1'b1;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    // Silence follows pause immediately, not one cycle later.
    always_comb begin
        fullnote = 10'd0;
        if ((r_state == S_PLAY) && !sound_off) begin
            fullnote = {4'b0000, r_note};
        end
    end

    assign rom_addr  = {r_song, r_idx};
    assign step_idx  = r_idx;
    assign song_done = r_songDone;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
// Directed bench for note_sequencer with TICK_DIV=4. dut0 uses GAP_TICKS=0
// and dut1 uses GAP_TICKS=1. Each has its own ROM model with one cycle of
// read latency. Cycle N is the Nth rising edge after RESET is released.
// Outputs are sampled 1 time unit after that edge.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       RESET;
    logic       sound_off;
    logic       song_sel;

    logic [8:0] romAddr0, romAddr1;
    logic [9:0] romData0, romData1;
    logic [9:0] fullnote0, fullnote1;
    logic [7:0] stepIdx0, stepIdx1;
    logic       songDone0, songDone1;

    logic [9:0] rom0 [512];
    logic [9:0] rom1 [512];

    int checks    = 0;
    int failures  = 0;
    int highCount = 0;
    int doneCount = 0;

    always #5 clk = ~clk;

    // Synchronous ROM models: data appears one cycle after the address.
    always @(posedge clk) begin
        romData0 <= rom0[romAddr0];
        romData1 <= rom1[romAddr1];
    end

    note_sequencer #(.TICK_DIV(4), .GAP_TICKS(0)) dut0 (
        .clk       (clk),
        .RESET     (RESET),
        .sound_off (sound_off),
        .song_sel  (song_sel),
        .rom_addr  (romAddr0),
        .rom_data  (romData0),
        .fullnote  (fullnote0),
        .step_idx  (stepIdx0),
        .song_done (songDone0)
    );

    note_sequencer #(.TICK_DIV(4), .GAP_TICKS(1)) dut1 (
        .clk       (clk),
        .RESET     (RESET),
        .sound_off (sound_off),
        .song_sel  (song_sel),
        .rom_addr  (romAddr1),
        .rom_data  (romData1),
        .fullnote  (fullnote1),
        .step_idx  (stepIdx1),
        .song_done (songDone1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic off, input logic sel);
        RESET     = rst;
        sound_off = off;
        song_sel  = sel;
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic holdReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        RESET     = 1'b1;
        sound_off = 1'b0;
        song_sel  = 1'b0;
        for (int i = 0; i < 512; i++) begin
            rom0[i] = 10'd0;
            rom1[i] = 10'd0;
        end

        // Test 1: note, rest, end marker
        rom0[0] = {4'd2, 6'd5};
        rom0[1] = {4'd1, 6'd0};
        rom0[2] = 10'd0;
        holdReset();
        checkOutput("rst_fullnote", fullnote0, 10'd0);
        checkOutput("rst_rom_addr", romAddr0, 9'd0);
        checkOutput("rst_step_idx", stepIdx0, 8'd0);
        checkOutput("rst_song_done", songDone0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        cycles(1);
        checkOutput("t1_c1_addr", romAddr0, 9'd0);
        checkOutput("t1_c1_silent", fullnote0, 10'd0);
        cycles(1);
        checkOutput("t1_c2_silent", fullnote0, 10'd0);
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            checkOutput("t1_note_on", fullnote0, 10'd5);
        end
        cycles(1);
        checkOutput("t1_c11_silent", fullnote0, 10'd0);
        checkOutput("t1_c11_addr", romAddr0, 9'd1);
        checkOutput("t1_c11_idx", stepIdx0, 8'd1);
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            checkOutput("t1_rest_silent", fullnote0, 10'd0);
        end
        cycles(1);
        checkOutput("t1_c17_addr", romAddr0, 9'd2);
        checkOutput("t1_c17_done", songDone0, 1'b0);
        cycles(2);
        checkOutput("t1_c19_done", songDone0, 1'b1);
        checkOutput("t1_c19_addr", romAddr0, 9'd0);
        cycles(1);
        checkOutput("t1_c20_done", songDone0, 1'b0);
        cycles(1);
        checkOutput("t1_c21_replay", fullnote0, 10'd5);

        // Test 2: one gap tick after each note (dut1)
        rom1[0] = {4'd1, 6'd12};
        rom1[1] = {4'd1, 6'd13};
        rom1[2] = 10'd0;
        holdReset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        cycles(2);
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            checkOutput("t2_note12", fullnote1, 10'd12);
        end
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            checkOutput("t2_gap_silent", fullnote1, 10'd0);
            if (i == 3) checkOutput("t2_gap_idx", stepIdx1, 8'd0);
        end
        checkOutput("t2_next_idx", stepIdx1, 8'd1);
        cycles(1);
        checkOutput("t2_note13", fullnote1, 10'd13);

        // Test 3: pause for 10 cycles in the middle of the 8-cycle note
        holdReset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        highCount = 0;
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            if (fullnote0 == 10'd5) highCount++;
        end
        cycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_paused_silent", fullnote0, 10'd0);
        for (int i = 0; i < 9; i++) begin
            cycles(1);
            checkOutput("t3_paused_silent", fullnote0, 10'd0);
        end
        checkOutput("t3_paused_idx", stepIdx0, 8'd0);
        cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        if (fullnote0 == 10'd5) highCount++;
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            if (fullnote0 == 10'd5) highCount++;
        end
        checkOutput("t3_high_time", highCount, 8);
        checkOutput("t3_next_idx", stepIdx0, 8'd1);

        // Test 4: switch to song 2 during a song-1 note
        rom0[256] = {4'd1, 6'd9};
        rom0[257] = 10'd0;
        holdReset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        cycles(4);
        checkOutput("t4_song1_on", fullnote0, 10'd5);
        applyStimulus(1'b0, 1'b0, 1'b1);
        cycles(1);
        checkOutput("t4_restart_silent", fullnote0, 10'd0);
        checkOutput("t4_restart_addr", romAddr0, 9'd256);
        checkOutput("t4_restart_done", songDone0, 1'b0);
        cycles(1);
        checkOutput("t4_fetch_silent", fullnote0, 10'd0);
        checkOutput("t4_fetch_done", songDone0, 1'b0);
        cycles(1);
        checkOutput("t4_song2_on", fullnote0, 10'd9);
        cycles(6);
        checkOutput("t4_song2_end_done", songDone0, 1'b1);
        checkOutput("t4_song2_end_addr", romAddr0, 9'd256);

        // Test 5: 256 one-tick notes with no end marker wrap to entry 0
        for (int i = 0; i < 256; i++) rom0[i] = {4'd1, 6'd1};
        holdReset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        doneCount = 0;
        for (int c = 1; c <= 1538; c++) begin
            cycles(1);
            if (songDone0) doneCount++;
            if (c == 1536) begin
                checkOutput("t5_last_idx", stepIdx0, 8'd255);
                checkOutput("t5_last_note", fullnote0, 10'd1);
            end
            if (c == 1537) begin
                checkOutput("t5_wrap_done", songDone0, 1'b1);
                checkOutput("t5_wrap_idx", stepIdx0, 8'd0);
                checkOutput("t5_wrap_addr", romAddr0, 9'd0);
            end
            if (c == 1538) checkOutput("t5_done_cleared", songDone0, 1'b0);
        end
        checkOutput("t5_done_count", doneCount, 1);

        // Test 6: asynchronous reset in the middle of entry 1
        cycles(8);
        checkOutput("t6_pre_note", fullnote0, 10'd1);
        checkOutput("t6_pre_idx", stepIdx0, 8'd1);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("t6_async_silent", fullnote0, 10'd0);
        checkOutput("t6_async_addr", romAddr0, 9'd0);
        checkOutput("t6_async_idx", stepIdx0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6_held_silent", fullnote0, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        cycles(2);
        checkOutput("t6_restart_c2", fullnote0, 10'd0);
        cycles(1);
        checkOutput("t6_restart_note", fullnote0, 10'd1);
        checkOutput("t6_restart_idx", stepIdx0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
